// File: rtl/td4_register_bank_if.sv
// td4_register_bank_if: bus between the TD4 decoder/adder side and the
// register bank. The master drives the adder result and load enables;
// the slave (register bank) returns the architectural state and the
// instruction-commit tick.
interface td4_register_bank_if;
   logic [3:0] alu_result;
   logic       alu_carry;
   logic [3:0] ld;
   logic [3:0] reg_a;
   logic [3:0] reg_b;
   logic [3:0] out_port;
   logic [3:0] pc;
   logic       c_flag;
   logic       tick;

   modport master (
      output alu_result, alu_carry, ld,
      input  reg_a, reg_b, out_port, pc, c_flag, tick
   );

   modport slave (
      input  alu_result, alu_carry, ld,
      output reg_a, reg_b, out_port, pc, c_flag, tick
   );
endinterface

// File: rtl/td4_register_bank.sv
// td4_register_bank: TD4 architectural state (A, B, OUT, PC, carry) plus
// the execution-rate divider that paces instruction commits.
// Registers capture the adder result only on commit edges, selected by
// the one-hot ld enables; PC increments when not jumping.
// Optional build macro STEP_MODE_EN: adds the step_n push button. Commits
// then happen once per debounced press instead of free-running.
module td4_register_bank #(
   parameter int unsigned DIV = 32'd50000000,
   parameter int unsigned CW  = 32
) (
   input  logic               clk,
   input  logic               n_reset,
`ifdef STEP_MODE_EN
   input  logic               step_n,
`endif
   td4_register_bank_if.slave bus
);

   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] count;
   logic          commit;

   logic [3:0]    reg_a_q;
   logic [3:0]    reg_b_q;
   logic [3:0]    out_q;
   logic [3:0]    pc_q;
   logic          c_q;
   logic          tick_q;

`ifdef STEP_MODE_EN
   logic sync_1;
   logic sync_2;
   logic db_q;
   logic db_prev;

   // Two-flop synchronizer for the asynchronous push button.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= step_n;
         sync_2 <= sync_1;
      end
   end

   // Divider doubles as debounce timer: runs only while the synchronized
   // input disagrees with the debounced level, restarts on any bounce back.
   always_ff @(posedge clk) begin
      if (!n_reset)
         count <= '0;
      else if (sync_2 == db_q || count == DIV_LAST)
         count <= '0;
      else
         count <= count + CNT_ONE;
   end

   // Debounced level; reset treats the button as pressed so a press held
   // through reset must be released before it can commit.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         db_q    <= 1'b0;
         db_prev <= 1'b0;
      end else begin
         if (sync_2 != db_q && count == DIV_LAST)
            db_q <= sync_2;
         db_prev <= db_q;
      end
   end

   // One commit per falling edge of the debounced button.
   always_comb commit = db_prev & ~db_q;
`else
   // Free-running divider: wraps to 0 on the commit cycle.
   always_ff @(posedge clk) begin
      if (!n_reset)
         count <= '0;
      else if (count == DIV_LAST)
         count <= '0;
      else
         count <= count + CNT_ONE;
   end

   // Commit on the last count of each divider period.
   always_comb commit = (count == DIV_LAST);
`endif

   // Architectural registers and the registered tick, updated on commit.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         reg_a_q <= 4'h0;
         reg_b_q <= 4'h0;
         out_q   <= 4'h0;
         pc_q    <= 4'h0;
         c_q     <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= commit;
         if (commit) begin
            if (bus.ld[0]) reg_a_q <= bus.alu_result;
            if (bus.ld[1]) reg_b_q <= bus.alu_result;
            if (bus.ld[2]) out_q   <= bus.alu_result;
            pc_q <= bus.ld[3] ? bus.alu_result : pc_q + 4'd1;
            c_q  <= bus.alu_carry;
         end
      end
   end

   // All outputs come straight from flops.
   assign bus.reg_a    = reg_a_q;
   assign bus.reg_b    = reg_b_q;
   assign bus.out_port = out_q;
   assign bus.pc       = pc_q;
   assign bus.c_flag   = c_q;
   assign bus.tick     = tick_q;

endmodule
